pipe_fetch: RTL and testbench

//  IF stage of the 5-stage RV64I pipeline: owns the PC, issues instruction-bus reads, and loads the F/D register.

---
 rtl/pipes_pkg.sv | 18 +
 rtl/pipe_fetch.sv | 114 +++++++++++
 tb/tb_pipe_fetch.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipes_pkg.sv
// rtl/pipes_pkg.sv - shared pipeline types for the fetch stage
package pipes;

  typedef struct packed {
    logic        valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
  } fetch_data_t;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/pipe_fetch.sv
// rtl/pipe_fetch.sv - IF stage: PC, instruction-bus requests, F/D register
// Optional bubble counter output enabled by FETCH_BUBBLE_CNT_EN.
module pipe_fetch
  import pipes::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
`ifdef FETCH_BUBBLE_CNT_EN
  output logic [63:0] bubble_cnt,
`endif
  output fetch_data_t dataF
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [95:0]  hold_q, hold_d;
  logic [63:0]  discard_addr_q, discard_addr_d;
  fetch_data_t  data_q, data_d;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_d         = hold_q;
    discard_addr_d = discard_addr_q;
    data_d         = data_q;
    ireq_valid     = (state_q != HOLD);
    ireq_addr      = (state_q == DISCARD) ? discard_addr_q : pc_q;

    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d         = redirect_pc;
          data_d.valid = 1'b0;
          if (!iresp_data_ok) begin
            // The outstanding read must still complete at its original address.
            state_d        = DISCARD;
            discard_addr_d = pc_q;
          end
        end else if (iresp_data_ok) begin
          pc_d = pc_q + PC_STEP;
          if (!stall) begin
            data_d = {1'b1, iresp_data, pc_q};
          end else begin
            hold_d  = {iresp_data, pc_q};
            state_d = HOLD;
          end
        end else if (!stall) begin
          data_d.valid = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          hold_d       = '0;
          data_d.valid = 1'b0;
          pc_d         = redirect_pc;
          state_d      = FETCH;
        end else if (!stall) begin
          data_d  = {1'b1, hold_q};
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (iresp_data_ok) state_d = FETCH;
        if (!stall || redirect_valid) data_d.valid = 1'b0;
      end
      default: state_d = FETCH;
    endcase
  end

`ifdef FETCH_BUBBLE_CNT_EN
  logic [63:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!stall && !data_d.valid) bubble_cnt_d = bubble_cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= FETCH;
      pc_q           <= PC_RESET;
      hold_q         <= '0;
      discard_addr_q <= '0;
      data_q         <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_q         <= hold_d;
      discard_addr_q <= discard_addr_d;
      data_q         <= data_d;
    end
  end

  assign dataF = data_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// tb/tb_pipe_fetch.sv - directed self-checking bench for pipe_fetch
module tb_pipe_fetch;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  fetch_data_t dataF;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [63:0] bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_BUBBLE_CNT_EN
    .bubble_cnt     (bubble_cnt),
`endif
    .dataF          (dataF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iresp_data_ok  = 1'b0;
    iresp_data     = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (dataF !== fetch_data_t'(97'd0)) begin
      bad++; $display("FAIL reset_dataF got=%h exp=0", dataF);
    end
    total++;
    if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0000}) begin
      bad++; $display("FAIL reset_ireq got=%b/%h exp=1/80000000", ireq_valid, ireq_addr);
    end
  endtask

  task automatic test_stream();
    logic [63:0] a;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a = 64'h8000_0000 + 64'(4 * i);
      total++;
      if (ireq_addr !== a) begin
        bad++; $display("FAIL stream_addr%0d got=%h exp=%h", i, ireq_addr, a);
      end
      iresp_data_ok = 1'b1;
      iresp_data    = word_of(a);
      step();
      total++;
      if (dataF !== {1'b1, word_of(a), a}) begin
        bad++; $display("FAIL stream_data%0d got=%h exp=%h", i, dataF, {1'b1, word_of(a), a});
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall_hold();
    do_reset();
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(64'h8000_0000);
    step();
    iresp_data    = word_of(64'h8000_0004);
    stall         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      iresp_data_ok = 1'b0;
      total++;
      if ({dataF.valid, dataF.pc, ireq_valid} !== {1'b1, 64'h8000_0000, 1'b0}) begin
        bad++; $display("FAIL hold%0d got v=%b pc=%h ireq=%b exp v=1 pc=80000000 ireq=0",
                        i, dataF.valid, dataF.pc, ireq_valid);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (dataF !== {1'b1, word_of(64'h8000_0004), 64'h8000_0004}) begin
      bad++; $display("FAIL hold_release got=%h exp pc=80000004", dataF);
    end
    total++;
    if ({ireq_valid, ireq_addr} !== {1'b1, 64'h8000_0008}) begin
      bad++; $display("FAIL hold_next_addr got=%b/%h exp=1/80000008", ireq_valid, ireq_addr);
    end
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(64'h8000_0008);
    step();
    total++;
    if (dataF !== {1'b1, word_of(64'h8000_0008), 64'h8000_0008}) begin
      bad++; $display("FAIL hold_after got=%h exp pc=80000008", dataF);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_pending();
    do_reset();
    iresp_data_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      iresp_data = word_of(64'h8000_0000 + 64'(4 * i));
      step();
    end
    idle_inputs();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    total++;
    if ({dataF.valid, ireq_valid, ireq_addr} !== {1'b0, 1'b1, 64'h8000_0008}) begin
      bad++; $display("FAIL discard_enter got v=%b ireq=%b addr=%h exp v=0 ireq=1 addr=80000008",
                      dataF.valid, ireq_valid, ireq_addr);
    end
    step();
    total++;
    if (ireq_addr !== 64'h8000_0008) begin
      bad++; $display("FAIL discard_addr_stable got=%h exp=80000008", ireq_addr);
    end
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(64'h8000_0008);
    step();
    total++;
    if ({dataF.valid, ireq_addr} !== {1'b0, 64'h8000_0100}) begin
      bad++; $display("FAIL discard_drop got v=%b addr=%h exp v=0 addr=80000100", dataF.valid, ireq_addr);
    end
    iresp_data = word_of(64'h8000_0100);
    step();
    total++;
    if (dataF !== {1'b1, word_of(64'h8000_0100), 64'h8000_0100}) begin
      bad++; $display("FAIL redirect_target got=%h exp pc=80000100", dataF);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    iresp_data_ok  = 1'b1;
    iresp_data     = word_of(64'h8000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    total++;
    if ({dataF.valid, ireq_valid, ireq_addr} !== {1'b0, 1'b1, 64'h8000_0200}) begin
      bad++; $display("FAIL same_cycle got v=%b ireq=%b addr=%h exp v=0 ireq=1 addr=80000200",
                      dataF.valid, ireq_valid, ireq_addr);
    end
    iresp_data = word_of(64'h8000_0200);
    step();
    total++;
    if (dataF !== {1'b1, word_of(64'h8000_0200), 64'h8000_0200}) begin
      bad++; $display("FAIL same_cycle_next got=%h exp pc=80000200", dataF);
    end
    // Redirect while decode is stalled must still kill the valid F/D entry.
    iresp_data_ok  = 1'b0;
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0300;
    step();
    total++;
    if (dataF.valid !== 1'b0) begin
      bad++; $display("FAIL redirect_under_stall got v=%b exp v=0", dataF.valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0400;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({dataF.valid, ireq_valid, ireq_addr} !== {1'b0, 1'b1, 64'h8000_0000}) begin
      bad++; $display("FAIL reset_in_discard got v=%b ireq=%b addr=%h exp v=0 ireq=1 addr=80000000",
                      dataF.valid, ireq_valid, ireq_addr);
    end
    iresp_data_ok = 1'b1;
    iresp_data    = word_of(64'h8000_0000);
    stall         = 1'b1;
    step();
    total++;
    if (ireq_valid !== 1'b0) begin
      bad++; $display("FAIL enter_hold got ireq=%b exp=0", ireq_valid);
    end
    idle_inputs();
    stall = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({dataF.valid, ireq_valid, ireq_addr} !== {1'b0, 1'b1, 64'h8000_0000}) begin
      bad++; $display("FAIL reset_in_hold got v=%b ireq=%b addr=%h exp v=0 ireq=1 addr=80000000",
                      dataF.valid, ireq_valid, ireq_addr);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'hDEAD_BEEF;
    step();
    total++;
    if (ireq_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      bad++; $display("FAIL wrap_addr got=%h exp=fffffffffffffffc", ireq_addr);
    end
    iresp_data = word_of(64'hFFFF_FFFF_FFFF_FFFC);
    step();
    total++;
    if (dataF !== {1'b1, word_of(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC}) begin
      bad++; $display("FAIL wrap_data got=%h exp pc=fffffffffffffffc", dataF);
    end
    total++;
    if (ireq_addr !== 64'h0) begin
      bad++; $display("FAIL wrap_next got=%h exp=0", ireq_addr);
    end
`ifdef FETCH_BUBBLE_CNT_EN
    // Two bubbles since reset: the redirect cycle and the discarded response.
    total++;
    if (bubble_cnt !== 64'd2) begin
      bad++; $display("FAIL bubble_cnt got=%0d exp=2", bubble_cnt);
    end
`endif
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_stream();
    test_stall_hold();
    test_redirect_pending();
    test_redirect_same_cycle();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
